// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and request struct for the shifter request path
package shift_pkg;
  localparam int DATA_W    = 32;
  localparam int SHAMT_W   = 5;
  // Queue storage carries tags at this width; narrower TAG_W values are zero-extended.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [SHAMT_W-1:0]   shift;
    logic                 rot;
    logic [TAG_MAX_W-1:0] tag;
  } shift_req_t;
endpackage

// File: rtl/shift_req_queue_if.sv
// rtl/shift_req_queue_if.sv - request handshake and result bundle of shift_req_queue
interface shift_req_queue_if
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [DATA_W-1:0]  req_a;
  logic [SHAMT_W-1:0] req_shift;
  logic               req_rot;
  logic [TAG_W-1:0]   req_tag;
  logic               res_valid;
  logic [DATA_W-1:0]  res_data;
  logic [TAG_W-1:0]   res_tag;

  modport master (
    output req_valid, req_a, req_shift, req_rot, req_tag,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_a, req_shift, req_rot, req_tag,
    output req_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/shift_tag_pipe.sv
// rtl/shift_tag_pipe.sv - PIPE_LAT-deep valid/tag delay line matched to the shifter latency
module shift_tag_pipe #(
  parameter int PIPE_LAT = 5,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);
  logic [PIPE_LAT-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [PIPE_LAT];
  logic [TAG_W-1:0]    tag_d [PIPE_LAT];

  always_comb begin
    valid_d[0] = in_valid;
    tag_d[0]   = in_tag;
    for (int i = 1; i < PIPE_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
    // Clear only kills validity; tags behind a zero valid are don't-care.
    if (clr) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign out_valid = valid_q[PIPE_LAT-1];
  assign out_tag   = tag_q[PIPE_LAT-1];
endmodule

// File: rtl/shift_req_queue.sv
// rtl/shift_req_queue.sv - request queue and issue stage ahead of the pipelined barrel shifter
// Optional SHIFTQ_BYPASS_EN: a push into an empty queue loads the issue register directly.
module shift_req_queue
  import shift_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int PIPE_LAT = 5,
  parameter  int TAG_W    = 4,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  shift_req_queue_if.slave   bus,
  input  logic               issue_en,
  input  logic               flush,
  output logic [DATA_W-1:0]  sh_a,
  output logic [SHAMT_W-1:0] sh_shift,
  output logic               sh_rot,
  input  logic [DATA_W-1:0]  sh_out,
  output logic [CNT_W-1:0]   count
);
  shift_req_t         mem_q [DEPTH];
  shift_req_t         wr_req;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  sh_a_q, sh_a_d;
  logic [SHAMT_W-1:0] sh_shift_q, sh_shift_d;
  logic               sh_rot_q, sh_rot_d;
  logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
  logic               iss_valid_q, iss_valid_d;
  logic               push, pop, byp, wr_en;

  // Ready depends only on registered occupancy, never on req_valid.
  assign bus.req_ready = (count_q != CNT_W'(DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = issue_en && (count_q != '0) && !flush;

`ifdef SHIFTQ_BYPASS_EN
  assign byp = push && issue_en && (count_q == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  assign wr_en = push && !byp && !flush;

  always_comb begin
    wr_req       = '0;
    wr_req.a     = bus.req_a;
    wr_req.shift = bus.req_shift;
    wr_req.rot   = bus.req_rot;
    wr_req.tag   = TAG_MAX_W'(bus.req_tag);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sh_a_d      = sh_a_q;
    sh_shift_d  = sh_shift_q;
    sh_rot_d    = sh_rot_q;
    iss_tag_d   = iss_tag_q;
    iss_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop) begin
        sh_a_d      = mem_q[rd_ptr_q].a;
        sh_shift_d  = mem_q[rd_ptr_q].shift;
        sh_rot_d    = mem_q[rd_ptr_q].rot;
        iss_tag_d   = mem_q[rd_ptr_q].tag[TAG_W-1:0];
        iss_valid_d = 1'b1;
      end else if (byp) begin
        sh_a_d      = bus.req_a;
        sh_shift_d  = bus.req_shift;
        sh_rot_d    = bus.req_rot;
        iss_tag_d   = bus.req_tag;
        iss_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sh_a_q      <= '0;
      sh_shift_q  <= '0;
      sh_rot_q    <= 1'b0;
      iss_tag_q   <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sh_a_q      <= sh_a_d;
      sh_shift_q  <= sh_shift_d;
      sh_rot_q    <= sh_rot_d;
      iss_tag_q   <= iss_tag_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  // Payload storage is intentionally unreset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_req;
    end
  end

  shift_tag_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .in_valid  (iss_valid_q),
    .in_tag    (iss_tag_q),
    .out_valid (bus.res_valid),
    .out_tag   (bus.res_tag)
  );

  assign bus.res_data = sh_out;
  assign sh_a         = sh_a_q;
  assign sh_shift     = sh_shift_q;
  assign sh_rot       = sh_rot_q;
  assign count        = count_q;
endmodule

// File: tb/tb_shift_req_queue.sv
// tb/tb_shift_req_queue.sv - self-checking bench for shift_req_queue with an external shifter model
module tb_shift_req_queue;
  localparam int DEPTH    = 4;
  localparam int PIPE_LAT = 5;
  localparam int TAG_W    = 4;
`ifdef SHIFTQ_BYPASS_EN
  localparam int LAT_EXP = PIPE_LAT;
  localparam bit BYP     = 1'b1;
`else
  localparam int LAT_EXP = PIPE_LAT + 1;
  localparam bit BYP     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic        flush;
  logic [31:0] sh_a;
  logic [4:0]  sh_shift;
  logic        sh_rot;
  logic [31:0] sh_out;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  shift_req_queue_if #(.TAG_W(TAG_W)) bus ();

  shift_req_queue #(
    .DEPTH    (DEPTH),
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .issue_en (issue_en),
    .flush    (flush),
    .sh_a     (sh_a),
    .sh_shift (sh_shift),
    .sh_rot   (sh_rot),
    .sh_out   (sh_out),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s, input logic r);
    logic [63:0] w;
    w = {a, a} << s;
    return r ? w[63:32] : (a << s);
  endfunction

  // Stand-in for the downstream barrel shifter: PIPE_LAT registers from sampled inputs to out.
  logic [31:0] shp [PIPE_LAT];
  always @(posedge clk) begin
    shp[0] <= ref_shift(sh_a, sh_shift, sh_rot);
    for (int i = 1; i < PIPE_LAT; i++) shp[i] <= shp[i-1];
  end
  assign sh_out = shp[PIPE_LAT-1];

  // Reference model: a FIFO of accepted requests and a list of issued ones with their due edge.
  typedef struct { logic [31:0] a; logic [4:0] s; logic r; logic [3:0] t; } mreq_t;
  typedef struct { int due; logic [3:0] t; logic [31:0] d; } mres_t;
  mreq_t       mq[$];
  mres_t       fl[$];
  int          cyc = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_tag = '0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_count = '0;

  always @(posedge clk) begin
    mreq_t nr, h;
    logic  acc;
    cyc++;
    if (rst || flush) begin
      mq.delete();
      fl.delete();
    end else begin
      nr  = '{a: bus.req_a, s: bus.req_shift, r: bus.req_rot, t: bus.req_tag};
      acc = bus.req_valid && (mq.size() < DEPTH);
      if (BYP && acc && issue_en && mq.size() == 0) begin
        fl.push_back('{due: cyc + PIPE_LAT, t: nr.t, d: ref_shift(nr.a, nr.s, nr.r)});
      end else begin
        if (issue_en && mq.size() > 0) begin
          h = mq.pop_front();
          fl.push_back('{due: cyc + PIPE_LAT, t: h.t, d: ref_shift(h.a, h.s, h.r)});
        end
        if (acc) mq.push_back(nr);
      end
    end
    m_valid = 1'b0;
    if (fl.size() > 0 && fl[0].due == cyc) begin
      m_valid = 1'b1;
      m_tag   = fl[0].t;
      m_data  = fl[0].d;
      void'(fl.pop_front());
    end
    m_count = 3'(mq.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [4:0] s,
                         input logic r, input logic [3:0] t);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_shift = s;
    bus.req_rot   = r;
    bus.req_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; issue_en = 1'b0;
    set_req(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_tests++; if (bus.res_tag !== 4'd0) begin n_fail++; $display("FAIL reset_res_tag: got %0h want 0", bus.res_tag); end
    n_tests++; if ({sh_a, sh_shift, sh_rot} !== 38'd0) begin n_fail++; $display("FAIL reset_sh: got %0h/%0d/%b want 0", sh_a, sh_shift, sh_rot); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rotate();
    logic [31:0] ra [3] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    logic        rr [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  rt [3] = '{4'd3, 4'd5, 4'd6};
    logic [31:0] re [3] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    int          pulses;
    logic [31:0] got_d;
    logic [3:0]  got_t;
    for (int k = 0; k < 3; k++) begin
      issue_en = 1'b1;
      set_req(1'b1, ra[k], 5'd1, rr[k], rt[k]);
      tick();
      bus.req_valid = 1'b0;
      pulses = 0; got_d = '0; got_t = '0;
      for (int c = 0; c < 15; c++) begin
        tick();
        if (bus.res_valid === 1'b1) begin
          pulses++;
          got_d = bus.res_data;
          got_t = bus.res_tag;
        end
      end
      n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL rot%0d_pulses: got %0d want 1", k, pulses); end
      n_tests++; if (got_d !== re[k]) begin n_fail++; $display("FAIL rot%0d_data: got %08h want %08h", k, got_d, re[k]); end
      n_tests++; if (got_t !== rt[k]) begin n_fail++; $display("FAIL rot%0d_tag: got %0h want %0h", k, got_t, rt[k]); end
    end
  endtask

  task automatic test_latency();
    int   n;
    logic seen;
    issue_en = 1'b1;
    set_req(1'b1, 32'h0000_00f0, 5'd4, 1'b0, 4'd7);
    tick();
    bus.req_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.res_valid === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen || n != LAT_EXP) begin n_fail++; $display("FAIL latency: got %0d edges (seen=%b) want %0d", n, seen, LAT_EXP); end
    n_tests++; if (bus.res_data !== 32'h0000_0f00 || bus.res_tag !== 4'd7) begin n_fail++; $display("FAIL latency_payload: got %08h/%0h want 00000f00/7", bus.res_data, bus.res_tag); end
    tick();
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL latency_single_pulse: got %b want 0", bus.res_valid); end
  endtask

  task automatic test_fill();
    int tags [$];
    int first;
    issue_en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      set_req(1'b1, 32'(t + 1), 5'(t), 1'b0, 4'(t));
      n_tests++; if (bus.req_ready !== (t < 4)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", t, bus.req_ready, (t < 4)); end
      tick();
    end
    bus.req_valid = 1'b0;
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    issue_en = 1'b1;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        if (first < 0) first = c;
        n_tests++; if (c != first + tags.size()) begin n_fail++; $display("FAIL fill_consecutive: result %0d at cycle %0d want %0d", tags.size(), c, first + tags.size()); end
        tags.push_back(int'(bus.res_tag));
      end
    end
    n_tests++; if (tags.size() != 4) begin n_fail++; $display("FAIL fill_results: got %0d want 4", tags.size()); end
    for (int i = 0; i < tags.size() && i < 4; i++) begin
      n_tests++; if (tags[i] != i) begin n_fail++; $display("FAIL fill_order%0d: got tag %0d want %0d", i, tags[i], i); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp_d [$];
    int          exp_t [$];
    logic [31:0] a;
    int          got;
    issue_en = 1'b0;
    for (int t = 8; t < 12; t++) begin
      a = $urandom();
      set_req(1'b1, a, 5'(t), 1'(t & 1), 4'(t));
      exp_d.push_back(ref_shift(a, 5'(t), 1'(t & 1)));
      exp_t.push_back(t);
      tick();
    end
    bus.req_valid = 1'b0;
    issue_en = 1'b1;
    tick();
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_first_pop: got %0d want 3", count); end
    for (int t = 12; t < 15; t++) begin
      a = $urandom();
      set_req(1'b1, a, 5'(t), 1'(t & 1), 4'(t));
      exp_d.push_back(ref_shift(a, 5'(t), 1'(t & 1)));
      exp_t.push_back(t);
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_t%0d: got %b want 1", t, bus.req_ready); end
      tick();
      n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_count_t%0d: got %0d want 3", t, count); end
    end
    bus.req_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        if (got < exp_t.size()) begin
          n_tests++; if (bus.res_tag !== 4'(exp_t[got]) || bus.res_data !== exp_d[got]) begin
            n_fail++; $display("FAIL full_result%0d: got %0h/%08h want %0h/%08h", got, bus.res_tag, bus.res_data, exp_t[got], exp_d[got]);
          end
        end
        got++;
      end
    end
    n_tests++; if (got != 7) begin n_fail++; $display("FAIL full_result_count: got %0d want 7", got); end
  endtask

  task automatic test_flush();
    int          stray;
    int          pulses;
    logic [31:0] a;
    issue_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(1'b1, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'(t));
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    issue_en = 1'b0;
    for (int t = 3; t < 5; t++) begin
      set_req(1'b1, $urandom(), 5'd2, 1'b0, 4'(t));
      tick();
    end
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    flush = 1'b1; issue_en = 1'b1;
    set_req(1'b1, 32'h1234_5678, 5'd1, 1'b0, 4'd15);
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", bus.req_ready); end
    stray = (bus.res_valid === 1'b1) ? 1 : 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.res_valid !== 1'b0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL flush_stray_results: got %0d want 0", stray); end
    a = $urandom();
    set_req(1'b1, a, 5'd9, 1'b1, 4'd9);
    tick();
    bus.req_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        pulses++;
        n_tests++; if (bus.res_tag !== 4'd9 || bus.res_data !== ref_shift(a, 5'd9, 1'b1)) begin
          n_fail++; $display("FAIL flush_after: got %0h/%08h want 9/%08h", bus.res_tag, bus.res_data, ref_shift(a, 5'd9, 1'b1));
        end
      end
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL flush_after_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_midrun();
    int stray;
    int tries;
    issue_en = 1'b1;
    for (int t = 1; t < 3; t++) begin
      set_req(1'b1, $urandom(), 5'd3, 1'b1, 4'(t));
      tick();
    end
    issue_en = 1'b0;
    tries = 0;
    while (bus.req_ready === 1'b1 && tries < 8) begin
      set_req(1'b1, $urandom(), 5'd1, 1'b0, 4'(tries + 3));
      tick();
      tries++;
    end
    bus.req_valid = 1'b0;
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 4", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count); end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_res_valid: got %b want 0", bus.res_valid); end
    n_tests++; if (sh_a !== 32'd0) begin n_fail++; $display("FAIL midrst_sh_a: got %08h want 0", sh_a); end
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.res_valid !== 1'b0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL midrst_stray: got %0d want 0", stray); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      issue_en = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      set_req(1'($urandom_range(0, 9) < 6), $urandom(), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
      n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, m_count); end
      n_tests++; if (bus.req_ready !== (m_count != 3'd4)) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, (m_count != 3'd4)); end
      n_tests++; if (bus.res_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.res_valid, m_valid); end
      if (m_valid) begin
        n_tests++; if (bus.res_tag !== m_tag || bus.res_data !== m_data) begin
          n_fail++; $display("FAIL rand_result c%0d: got %0h/%08h want %0h/%08h", c, bus.res_tag, bus.res_data, m_tag, m_data);
        end
      end
    end
    flush = 1'b0;
    bus.req_valid = 1'b0;
    issue_en = 1'b1;
    for (int c = 0; c < 16; c++) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_en = 1'b0;
    set_req(1'b0, '0, '0, 1'b0, '0);
    test_reset();
    test_rotate();
    test_latency();
    test_fill();
    test_full_pushpop();
    test_flush();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_req_queue.md
# shift_req_queue

Request queue and issue stage that sits directly upstream of the pipelined barrel shifter. It buffers shift requests (operand, amount, rotate flag, tag) behind a valid/ready handshake and issues at most one per cycle into the shifter's input port. It carries each request's valid and tag down a delay line matched to the shifter latency, so results leave with `res_valid`/`res_tag` aligned to the shifter output.

## Interface
- `DEPTH`, 4: queue entries, power of two, ≥ 2.
- `PIPE_LAT`, 5: shifter latency in clk edges from sampled inputs to `out`.
- `TAG_W`, 4: request tag width.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  queue can accept a request.
- `req_a`  in  32  operand.
- `req_shift`  in  5  shift amount.
- `req_rot`  in  1  1 = rotate, 0 = logical shift.
- `req_tag`  in  TAG_W  request identifier.
- `issue_en`  in  1  0 = hold issue (shifter shared or paused).
- `flush`  in  1  discard queued and in-flight requests.
- `sh_a`  out  32  to shifter `a`.
- `sh_shift`  out  5  to shifter `shift`.
- `sh_rot`  out  1  to shifter `rot`.
- `sh_out`  in  32  from shifter `out`.
- `res_valid`  out  1  `res_data`/`res_tag` valid this cycle.
- `res_data`  out  32  equals `sh_out`.
- `res_tag`  out  TAG_W  tag of the result.
- `count`  out  clog2(DEPTH+1)  queue occupancy, excluding the issue register.

## Operation
- Queue is a circular buffer with `wr_ptr`/`rd_ptr` of clog2(DEPTH) bits that wrap modulo DEPTH. `count` is separate.
- Push happens when `req_valid && req_ready`. `req_ready = (count != DEPTH)`, registered-state derived, with no combinational path from `req_valid`.
- Issue register `{sh_a, sh_shift, sh_rot, iss_tag, iss_valid}`. At each edge:
  - If `issue_en` and `count != 0`: load the head, pop, set `iss_valid = 1`.
  - Otherwise: `iss_valid = 0` and the `sh_*` outputs hold their values.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. Push is allowed at `count == DEPTH-1` with a pop in the same cycle.
- Delay line: `PIPE_LAT` stages of `{valid, tag}` fed from `{iss_valid, iss_tag}`. Its last stage drives `res_valid`/`res_tag`. `res_data = sh_out`, combinational.
- Requests issue strictly in push order; results leave in issue order.
- `flush` (edge-sampled) clears as follows:
  - `count` and both pointers go to 0.
  - `iss_valid` and every delay-line valid go to 0.
  - A push in the same cycle is dropped.
  - `flush` has priority over push and issue.
- Reset values: `count = 0`, `req_ready = 1`, `sh_a = 0`, `sh_shift = 0`, `sh_rot = 0`, `iss_valid = 0`, all delay-line valids 0, `res_valid = 0`, `res_tag = 0`. Data storage is not reset. Reset asserted mid-operation behaves as `flush` plus zeroing of the `sh_*` outputs.

## Timing
- Request accepted at edge E into an empty queue with `issue_en = 1`: issue register loaded at E+1, `res_valid` high for exactly one cycle after edge E+1+PIPE_LAT.
- Throughput: one request per cycle sustained. A full queue with `issue_en = 1` drains one entry per cycle.
- `issue_en` low for k cycles inserts k bubbles into `res_valid`. Nothing already in flight is delayed.

## Configuration
- `SHIFTQ_BYPASS_EN` defined:
  - When `count == 0`, `issue_en = 1`, no `flush`, and a push occurs, the request loads straight into the issue register at the same edge and is not written to the queue.
  - Empty-queue latency drops to `res_valid` after edge E+PIPE_LAT.
- `SHIFTQ_BYPASS_EN` undefined: every request passes through the queue, adding one cycle of minimum latency.
- Ordering and all other behaviour are identical in both builds.

## Structure
- Shared package `shift_pkg` holds the operand width constant (32), the shift-amount width (5), and the request struct typedef `{a, shift, rot, tag}`.
- One sub-module, `shift_tag_pipe`: a parameterised `PIPE_LAT`-deep valid/tag delay line with synchronous clear.

## Test plan
- Rotate with wrap: `a = 1`, `shift = 1`, `rot = 1`, tag 3 → one `res_valid` pulse with `res_data = 2`, `res_tag = 3`. `a = 0x80000000`, `shift = 1`, `rot = 1` → `res_data = 1`. With `rot = 0` → `res_data = 0`.
- Latency: single request into an empty queue → `res_valid` exactly after edge E+1+5 (E+5 with `SHIFTQ_BYPASS_EN`).
- Fill: `issue_en = 0`, push tags 0..4 back to back → tags 0–3 accepted, `count = 4`, `req_ready = 0` on the 5th. Then set `issue_en = 1` → results arrive with tags 0,1,2,3 on consecutive cycles.
- Full with simultaneous push/pop: at `count = 4`, `issue_en = 1`, new push on the next cycle → accepted while `count` holds at 3→3, no lost or duplicated tags; pointers wrap past entry 3 correctly.
- Flush: three requests in flight plus two queued, assert `flush` one cycle → no further `res_valid`, `count = 0`, `req_ready = 1`. A request after the flush returns normally.
- Mid-run reset: assert `rst` with a full queue → next cycle `count = 0`, `res_valid = 0`, `sh_a = 0`, and no stale results appear over the following 8 cycles.
